event_buffer: RTL and testbench
===============================

EVENT_BUFFER -- requirements
Module: event_buffer

Interface
REQ-001: Parameter DEPTH, default 4, sets the FIFO entry count and SHALL be a power of two in the range 2..16.
REQ-002: Parameter AW, default 2, sets the pointer width and SHALL equal log2(DEPTH).
REQ-003: clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004: rst, input, 1, reset; synchronous and active-high.
REQ-005: in_event, input, 8, filtered event packed as {x[1:0], y[1:0], p[1:0], t[1:0]}, taken from the upstream event filter outputs.
REQ-006: in_valid, input, 1, qualifies in_event for one cycle; there is no backpressure to the upstream stage.
REQ-007: out_event, output, 8, head-of-FIFO event.
REQ-008: out_valid, output, 1, high while the FIFO is not empty.
REQ-009: out_ready, input, 1, consumer accepts out_event.
REQ-010: level, output, AW+1, current occupancy, 0..DEPTH.
REQ-011: overflow, output, 1, sticky flag set when an event is dropped.
REQ-012: ovf_clr, input, 1, clears overflow.
REQ-013: drop_cnt, output, 8, dropped-event counter; present only with EVENT_BUFFER_DROP_CNT_EN.

Function
REQ-014: Push SHALL occur when in_valid=1 and either level<DEPTH, or level=DEPTH with a pop in the same cycle.
REQ-015: Pop SHALL occur when out_valid=1 and out_ready=1.
REQ-016: The buffer SHALL be first-word-fall-through: out_event always equals the oldest stored entry while out_valid=1.
REQ-017: Latency from a push into an empty FIFO to out_valid=1 SHALL be exactly 1 cycle, with out_event equal to the pushed value.
REQ-018: out_event and out_valid SHALL be registered or driven directly from FIFO state, with no combinational path from in_event or in_valid.
REQ-019: On a simultaneous push and pop, level SHALL be unchanged, the head SHALL advance, and the new entry SHALL be appended.
REQ-020: When level=DEPTH, in_valid=1 and there is no pop, the event SHALL be discarded, stored data SHALL be unchanged, and overflow SHALL be set the next cycle.
REQ-021: When the FIFO is empty, a pop attempt is impossible because out_valid=0; level SHALL never go below 0.
REQ-022: Read and write pointers SHALL wrap modulo DEPTH; full and empty SHALL be determined from level only.
REQ-023: level SHALL update by +1 on push only, by -1 on pop only, and by 0 on both or neither.
REQ-024: When ovf_clr=1 and a drop occur in the same cycle, overflow SHALL remain 1 (set wins).
REQ-025: out_event SHALL hold stable while out_valid=1 and out_ready=0.

Reset
REQ-026: When rst=1 at a clock edge, level, both pointers, overflow and drop_cnt SHALL be 0.
REQ-027: After reset, out_valid SHALL be 0 and out_event SHALL be 8'h00.
REQ-028: Reset SHALL have priority over push, pop and ovf_clr.
REQ-029: Entries in flight at reset SHALL be lost, and no pop SHALL be reported in the reset cycle.
REQ-030: Storage RAM content need not be reset, but out_event SHALL read 8'h00 whenever out_valid=0.

Configuration
REQ-031: Macro EVENT_BUFFER_DROP_CNT_EN, when defined, SHALL add the drop_cnt port.
REQ-032: With EVENT_BUFFER_DROP_CNT_EN, drop_cnt SHALL increment by 1 per discarded event.
REQ-033: With EVENT_BUFFER_DROP_CNT_EN, drop_cnt SHALL saturate at 8'hFF.
REQ-034: With EVENT_BUFFER_DROP_CNT_EN, drop_cnt SHALL clear with ovf_clr, except that a same-cycle drop SHALL load 1.
REQ-035: Without EVENT_BUFFER_DROP_CNT_EN, neither the port nor the counter logic SHALL exist, and all other behaviour SHALL be identical.

Verification
REQ-036: Reset, then push 8'hA5 with out_ready=0 -> next cycle out_valid=1, out_event=8'hA5, level=1.
REQ-037: Push 8'h01, 8'h02, 8'h03, 8'h04, then pop four times -> outputs appear in order 01, 02, 03, 04, and level returns to 0 with out_valid=0.
REQ-038: Fill to DEPTH=4, then push 8'hFF with out_ready=0 -> dropped, level=4, overflow=1, drop_cnt=1, head unchanged.
REQ-039: Full FIFO, in_valid=1 and out_ready=1 in the same cycle -> level stays 4, old head retired, new event appears at the tail after 3 further pops.
REQ-040: 300 drops with EVENT_BUFFER_DROP_CNT_EN -> drop_cnt=8'hFF; then ovf_clr=1 with no drop -> overflow=0, drop_cnt=0.
REQ-041: Assert rst with level=3 and out_ready=1 -> next cycle level=0, out_valid=0, out_event=8'h00, overflow=0.

Source files
------------

// File: rtl/event_buffer.sv
// First-word-fall-through event FIFO with no upstream backpressure and a sticky overflow flag.
// Define EVENT_BUFFER_DROP_CNT_EN to add the saturating drop_cnt port and counter.
module event_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    in_event,
  input  logic          in_valid,
  output logic [7:0]    out_event,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW:0]   level,
`ifdef EVENT_BUFFER_DROP_CNT_EN
  output logic [7:0]    drop_cnt,
`endif
  output logic          overflow,
  input  logic          ovf_clr
);

  localparam int DATA_W = 8;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [AW:0]       level_q;
  logic              overflow_q;
  logic              full;
  logic              push;
  logic              pop;
  logic              drop;

  assign full      = (level_q == FULL_LVL);
  assign out_valid = (level_q != '0);
  assign pop       = out_valid && out_ready;
  // A full FIFO still accepts when the head retires in the same cycle.
  assign push      = in_valid && (!full || pop);
  assign drop      = in_valid && full && !pop;

  // Head is read straight from storage, so nothing from in_event reaches the outputs.
  assign out_event = out_valid ? mem[rd_ptr] : '0;
  assign level     = level_q;
  assign overflow  = overflow_q;

  // Storage carries no reset; stale words are masked by out_valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_event;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (push && !pop)      level_q <= level_q + (AW+1)'(1);
      else if (pop && !push) level_q <= level_q - (AW+1)'(1);
      if (drop)         overflow_q <= 1'b1;
      else if (ovf_clr) overflow_q <= 1'b0;
    end
  end

`ifdef EVENT_BUFFER_DROP_CNT_EN
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [7:0] drop_cnt_q;
  assign drop_cnt = drop_cnt_q;

  // A drop in the clearing cycle counts as the first event of the new window.
  always_ff @(posedge clk) begin
    if (rst)          drop_cnt_q <= '0;
    else if (ovf_clr) drop_cnt_q <= drop ? 8'd1 : 8'd0;
    else if (drop)    drop_cnt_q <= sat_inc(drop_cnt_q);
  end
`endif

endmodule

// File: tb/tb_event_buffer.sv
// Bench for event_buffer: directed scenarios plus randomized traffic against a queue-based model.
module tb_event_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  in_event = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  out_event;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [AW:0] level;
  logic        overflow;
  logic        ovf_clr = 1'b0;
`ifdef EVENT_BUFFER_DROP_CNT_EN
  logic [7:0]  drop_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [7:0] mq[$];
  bit         m_ovf = 0;
  int         m_dcnt = 0;

  event_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_event  (in_event),
    .in_valid  (in_valid),
    .out_event (out_event),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
`ifdef EVENT_BUFFER_DROP_CNT_EN
    .drop_cnt  (drop_cnt),
`endif
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit v, input logic [7:0] e, input bit rd, input bit c);
    bit full, pop, push, drop;
    if (r) begin
      mq.delete();
      m_ovf  = 0;
      m_dcnt = 0;
    end else begin
      full = (mq.size() == DEPTH);
      pop  = (mq.size() > 0) && rd;
      push = v && (!full || pop);
      drop = v && full && !pop;
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(e);
      if (drop)   m_ovf = 1;
      else if (c) m_ovf = 0;
      if (c)         m_dcnt = drop ? 1 : 0;
      else if (drop) m_dcnt = (m_dcnt >= 255) ? 255 : m_dcnt + 1;
    end
  endtask

  task automatic check_model(input string tag);
    check_eq({tag, ".level"}, 32'(level), 32'(mq.size()));
    check_eq({tag, ".valid"}, 32'(out_valid), 32'(mq.size() > 0));
    check_eq({tag, ".event"}, 32'(out_event), (mq.size() > 0) ? 32'(mq[0]) : 32'h0);
    check_eq({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
`ifdef EVENT_BUFFER_DROP_CNT_EN
    check_eq({tag, ".dcnt"}, 32'(drop_cnt), 32'(m_dcnt));
`endif
  endtask

  // Applies one cycle of inputs (called while clk is low), advances the model, samples on the falling edge.
  task automatic cyc(input bit r, input bit v, input logic [7:0] e, input bit rd, input bit c,
                     input bit do_chk = 1'b0, input string tag = "cyc");
    rst = r; in_valid = v; in_event = e; out_ready = rd; ovf_clr = c;
    model_step(r, v, e, rd, c);
    @(posedge clk);
    @(negedge clk);
    if (do_chk) check_model(tag);
  endtask

  initial begin
    // Reset state
    cyc(1, 0, 8'h00, 0, 0);
    cyc(1, 0, 8'h00, 0, 0, 1, "reset");
    check_eq("reset.event_zero", 32'(out_event), 32'h0);

    // Single push into empty FIFO: one-cycle fall-through
    cyc(0, 1, 8'hA5, 0, 0, 1, "push1");
    check_eq("push1.event_a5", 32'(out_event), 32'hA5);
    check_eq("push1.level_1", 32'(level), 32'd1);

    // Ordering 01..04
    cyc(1, 0, 8'h00, 0, 0);
    for (int i = 1; i <= 4; i++) cyc(0, 1, 8'(i), 0, 0, 1, "fill");
    for (int i = 1; i <= 4; i++) begin
      check_eq("order.head", 32'(out_event), 32'(i));
      cyc(0, 0, 8'h00, 1, 0, 1, "drain");
    end
    check_eq("order.empty_level", 32'(level), 32'd0);
    check_eq("order.empty_valid", 32'(out_valid), 32'd0);

    // Overflow on full FIFO without pop
    for (int i = 0; i < 4; i++) cyc(0, 1, 8'h10 + 8'(i), 0, 0);
    cyc(0, 1, 8'hFF, 0, 0, 1, "drop");
    check_eq("drop.level", 32'(level), 32'd4);
    check_eq("drop.ovf", 32'(overflow), 32'd1);
    check_eq("drop.head", 32'(out_event), 32'h10);
`ifdef EVENT_BUFFER_DROP_CNT_EN
    check_eq("drop.dcnt", 32'(drop_cnt), 32'd1);
`endif

    // Full FIFO with simultaneous push and pop
    cyc(0, 1, 8'h77, 1, 0, 1, "fullpp");
    check_eq("fullpp.level", 32'(level), 32'd4);
    check_eq("fullpp.head", 32'(out_event), 32'h11);
    for (int i = 0; i < 3; i++) cyc(0, 0, 8'h00, 1, 0, 1, "fullpp_drain");
    check_eq("fullpp.tail", 32'(out_event), 32'h77);

    // Saturation after many drops, then clear
    for (int i = 0; i < 3; i++) cyc(0, 1, 8'h20 + 8'(i), 0, 0);
    for (int i = 0; i < 300; i++) cyc(0, 1, 8'(i), 0, 0);
    check_model("sat");
`ifdef EVENT_BUFFER_DROP_CNT_EN
    check_eq("sat.dcnt_ff", 32'(drop_cnt), 32'hFF);
`endif
    cyc(0, 0, 8'h00, 0, 1, 1, "clr");
    check_eq("clr.ovf", 32'(overflow), 32'd0);
`ifdef EVENT_BUFFER_DROP_CNT_EN
    check_eq("clr.dcnt", 32'(drop_cnt), 32'd0);
`endif

    // Clear coinciding with a drop: set wins
    cyc(0, 1, 8'h55, 0, 1, 1, "clrdrop");
    check_eq("clrdrop.ovf", 32'(overflow), 32'd1);

    // Reset with level 3 and consumer ready
    cyc(0, 0, 8'h00, 1, 0, 1, "to3");
    check_eq("to3.level", 32'(level), 32'd3);
    cyc(1, 1, 8'h99, 1, 1, 1, "rst3");
    check_eq("rst3.level", 32'(level), 32'd0);
    check_eq("rst3.valid", 32'(out_valid), 32'd0);
    check_eq("rst3.event", 32'(out_event), 32'h0);
    check_eq("rst3.ovf", 32'(overflow), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 60), 8'($urandom),
          ($urandom_range(0, 99) < 45), ($urandom_range(0, 49) == 0), 1, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
